// File: rtl/ram_sp_rr_arbiter.sv
// Two-client round-robin arbiter in front of a single-port DEPTHxDATA_W RAM, one access per clock.
// Grant is combinational in the request cycle; read data and rvalid arrive one cycle after grant.
// A losing client holds its request until granted; under contention grants alternate A/B.
module ram_sp_rr_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rr_ptr;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rvalid_a_q;
  logic              rvalid_b_q;
  logic              busy_q;

  logic              gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // rr_ptr holds the last winner, so a conflict goes to the other client.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst) begin
      if (req_a && req_b) begin
        gnt_a = rr_ptr;
        gnt_b = ~rr_ptr;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  assign gnt       = gnt_a | gnt_b;
  assign sel_we    = gnt_b ? we_b    : we_a;
  assign sel_addr  = gnt_b ? addr_b  : addr_a;
  assign sel_wdata = gnt_b ? wdata_b : wdata_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= 1'b1;
      rd_addr_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      busy_q     <= gnt;
      rvalid_a_q <= gnt_a & ~we_a;
      rvalid_b_q <= gnt_b & ~we_b;
      if (gnt) begin
        rr_ptr <= gnt_b;
      end
      if (gnt && !sel_we) begin
        rd_addr_q <= sel_addr;
      end
    end
  end

  // Contents survive reset; grants are already held low while rst is high.
  always_ff @(posedge clk) begin
    if (gnt && sel_we) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  // Reading through the registered address keeps rdata tracking the live array contents.
  assign rdata = mem[rd_addr_q];

  // A read accepted just before reset must not report valid while reset is asserted.
  assign rvalid_a = rvalid_a_q & ~rst;
  assign rvalid_b = rvalid_b_q & ~rst;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ram_sp_rr_arbiter.sv
// Directed bench for ram_sp_rr_arbiter: reset, single-client access, conflicts, RAW, reset mid-read, edge addresses.
module tb_ram_sp_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       req_a, we_a, req_b, we_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
  logic [7:0] rdata;

  int tests;
  int fails;

  ram_sp_rr_arbiter #(.DATA_W(8), .ADDR_W(6), .DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b),
    .rdata(rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_a = 1'b1; req_b = 1'b1; we_a = 1'b0; we_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if ({gnt_a, gnt_b} !== 2'b00) begin
        fails++; $display("FAIL reset_gnt cyc%0d: got %b expected 00", i, {gnt_a, gnt_b});
      end
      step();
      tests++;
      if ({rvalid_a, rvalid_b, busy} !== 3'b000) begin
        fails++; $display("FAIL reset_state cyc%0d: rvalid_a,rvalid_b,busy got %b expected 000", i, {rvalid_a, rvalid_b, busy});
      end
    end
    rst = 1'b0;
    idle();
    step();
  endtask

  task automatic test_write_read_a();
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'h10; wdata_a = 8'hA5;
    #1;
    tests++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      fails++; $display("FAIL wr_a_gnt: got %b expected 10", {gnt_a, gnt_b});
    end
    step();
    tests++;
    if ({busy, rvalid_a, rvalid_b} !== 3'b100) begin
      fails++; $display("FAIL wr_a_after: busy,rvalid_a,rvalid_b got %b expected 100", {busy, rvalid_a, rvalid_b});
    end
    we_a = 1'b0;
    #1;
    tests++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      fails++; $display("FAIL rd_a_gnt: got %b expected 10", {gnt_a, gnt_b});
    end
    step();
    req_a = 1'b0;
    tests++;
    if ({rvalid_a, rvalid_b} !== 2'b10 || rdata !== 8'hA5) begin
      fails++; $display("FAIL rd_a_data: rvalid_a,rvalid_b=%b rdata=%h expected 10 / a5", {rvalid_a, rvalid_b}, rdata);
    end
    step();
    tests++;
    if ({rvalid_a, rvalid_b, busy} !== 3'b000) begin
      fails++; $display("FAIL rd_a_idle: got %b expected 000", {rvalid_a, rvalid_b, busy});
    end
  endtask

  task automatic test_conflict();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h10;
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'h10;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if ({gnt_a, gnt_b} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL conflict_gnt cyc%0d: got %b expected %b", i, {gnt_a, gnt_b}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      step();
      tests++;
      if ({rvalid_a, rvalid_b} !== ((i % 2 == 0) ? 2'b10 : 2'b01) || rdata !== 8'hA5) begin
        fails++; $display("FAIL conflict_rvalid cyc%0d: got %b rdata=%h expected %b / a5", i, {rvalid_a, rvalid_b}, rdata, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
    idle();
    step();
    tests++;
    if ({rvalid_a, rvalid_b} !== 2'b00) begin
      fails++; $display("FAIL conflict_drain: got %b expected 00", {rvalid_a, rvalid_b});
    end
  endtask

  task automatic test_raw_cross();
    req_b = 1'b1; we_b = 1'b1; addr_b = 6'h3F; wdata_b = 8'h3C;
    #1;
    tests++;
    if ({gnt_a, gnt_b} !== 2'b01) begin
      fails++; $display("FAIL raw_wr_b_gnt: got %b expected 01", {gnt_a, gnt_b});
    end
    step();
    idle();
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h3F;
    #1;
    tests++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      fails++; $display("FAIL raw_rd_a_gnt: got %b expected 10", {gnt_a, gnt_b});
    end
    step();
    idle();
    tests++;
    if ({rvalid_a, rvalid_b} !== 2'b10 || rdata !== 8'h3C) begin
      fails++; $display("FAIL raw_data: rvalid=%b rdata=%h expected 10 / 3c", {rvalid_a, rvalid_b}, rdata);
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h10;
    #1;
    tests++;
    if (gnt_a !== 1'b1) begin
      fails++; $display("FAIL midrst_gnt: got %b expected 1", gnt_a);
    end
    step();
    idle();
    rst = 1'b1;
    #1;
    tests++;
    if (rvalid_a !== 1'b0) begin
      fails++; $display("FAIL midrst_rvalid_n1: got %b expected 0", rvalid_a);
    end
    step();
    rst = 1'b0;
    #1;
    tests++;
    if ({rvalid_a, busy} !== 2'b00) begin
      fails++; $display("FAIL midrst_rvalid_n2: rvalid_a,busy got %b expected 00", {rvalid_a, busy});
    end
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h10;
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'h3F;
    #1;
    tests++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      fails++; $display("FAIL midrst_conflict: got %b expected 10", {gnt_a, gnt_b});
    end
    step();
    idle();
    tests++;
    if ({rvalid_a, rvalid_b} !== 2'b10 || rdata !== 8'hA5) begin
      fails++; $display("FAIL midrst_reread: rvalid=%b rdata=%h expected 10 / a5", {rvalid_a, rvalid_b}, rdata);
    end
    step();
  endtask

  task automatic test_edges();
    req_a = 1'b1; we_a = 1'b1; addr_a = 6'h00; wdata_a = 8'h00;
    step();
    idle();
    req_b = 1'b1; we_b = 1'b1; addr_b = 6'h3F; wdata_b = 8'hFF;
    step();
    idle();
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'h00;
    step();
    idle();
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'h3F;
    tests++;
    if ({rvalid_a, rvalid_b} !== 2'b10 || rdata !== 8'h00) begin
      fails++; $display("FAIL edge_rd0: rvalid=%b rdata=%h expected 10 / 00", {rvalid_a, rvalid_b}, rdata);
    end
    step();
    idle();
    tests++;
    if ({rvalid_a, rvalid_b} !== 2'b01 || rdata !== 8'hFF) begin
      fails++; $display("FAIL edge_rd3f: rvalid=%b rdata=%h expected 01 / ff", {rvalid_a, rvalid_b}, rdata);
    end
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    idle();
    step();
    test_reset();
    test_write_read_a();
    test_conflict();
    test_raw_cross();
    test_reset_mid_read();
    test_edges();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
